decode_stage: RTL and testbench

- Registered, parametrised RV32I instruction-decode pipeline stage between fetch and execute.
- Accepts instruction and PC over a valid/ready handshake and decodes them into control fields.
- Presents the decoded result one cycle later, with a one-entry skid buffer for full throughput under backpressure.
- Adds illegal-instruction flagging, deterministic zero outputs for unused fields, pipeline flush, and a timed stall on the Zihintpause PAUSE hint.

---
 rtl/decode_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready input, one-entry skid buffer,
// illegal flagging, flush, and a counted in_ready stall after a PAUSE hint.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int PAUSE_CYCLES = 16,
  parameter bit PAUSE_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [15:0]     out_op_code,
  output logic [4:0]      out_rs1_sel,
  output logic [4:0]      out_rs2_sel,
  output logic [4:0]      out_rd_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_rd_data_sel,
  output logic            out_alu_sel,
  output logic            out_reg_w,
  output logic            out_data_r,
  output logic            out_data_w,
  output logic [1:0]      out_data_size,
  output logic            out_unsigned,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic            out_pause,
  output logic            pause_busy
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [15:0]     op_code;
    logic [4:0]      rs1_sel;
    logic [4:0]      rs2_sel;
    logic [4:0]      rd_sel;
    logic [XLEN-1:0] imm;
    logic [1:0]      rd_data_sel;
    logic            alu_sel;
    logic            reg_w;
    logic            data_r;
    logic            data_w;
    logic [1:0]      data_size;
    logic            is_unsigned;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic            pause;
  } bundle_t;

  typedef enum logic {ST_RUN, ST_PAUSE} state_t;

  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_CYCLES);

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  bundle_t     dec, out_reg, skid_reg;
  logic [6:0]  opc, f7, f7_shift;
  logic [2:0]  f3, f3_keep;
  logic [5:0]  f7_keep;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic        legal;

  // op_code packs fn7[5:0]: fn7[6] is zero in every legal RV32I encoding.
  always_comb begin
    opc   = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    if (XLEN == 64) begin
      f7_shift = {in_instr[31:26], 1'b0};
      shamt    = {26'b0, in_instr[25:20]};
    end else begin
      f7_shift = f7;
      shamt    = {27'b0, in_instr[24:20]};
    end
    dec     = '0;
    dec.pc  = in_pc;
    legal   = 1'b0;
    f3_keep = f3;
    f7_keep = '0;
    case (opc)
      7'b0110111: begin  // LUI
        legal = 1'b1; dec.rd_sel = in_instr[11:7]; dec.imm = sext(imm_u);
        dec.rd_data_sel = 2'b10; dec.reg_w = 1'b1; f3_keep = '0;
      end
      7'b0010111: begin  // AUIPC
        legal = 1'b1; dec.rd_sel = in_instr[11:7]; dec.imm = sext(imm_u);
        dec.alu_sel = 1'b1; dec.reg_w = 1'b1; f3_keep = '0;
      end
      7'b1101111: begin  // JAL
        legal = 1'b1; dec.rd_sel = in_instr[11:7]; dec.imm = sext(imm_j);
        dec.rd_data_sel = 2'b11; dec.alu_sel = 1'b1; dec.reg_w = 1'b1; dec.jump = 1'b1; f3_keep = '0;
      end
      7'b1100111: if (f3 == 3'b000) begin  // JALR
        legal = 1'b1; dec.rd_sel = in_instr[11:7]; dec.rs1_sel = in_instr[19:15]; dec.imm = sext(imm_i);
        dec.rd_data_sel = 2'b11; dec.alu_sel = 1'b1; dec.reg_w = 1'b1; dec.jump = 1'b1;
      end
      7'b1100011: if (f3[2:1] != 2'b01) begin  // branches
        legal = 1'b1; dec.rs1_sel = in_instr[19:15]; dec.rs2_sel = in_instr[24:20]; dec.imm = sext(imm_b);
        dec.alu_sel = 1'b1; dec.branch = 1'b1; dec.is_unsigned = f3[2] & f3[1];
      end
      7'b0000011: if (f3[1:0] != 2'b11 && f3 != 3'b110) begin  // loads
        legal = 1'b1; dec.rd_sel = in_instr[11:7]; dec.rs1_sel = in_instr[19:15]; dec.imm = sext(imm_i);
        dec.rd_data_sel = 2'b01; dec.alu_sel = 1'b1; dec.reg_w = 1'b1; dec.data_r = 1'b1;
        dec.data_size = f3[1:0]; dec.is_unsigned = f3[2];
      end
      7'b0100011: if (!f3[2] && f3[1:0] != 2'b11) begin  // stores
        legal = 1'b1; dec.rs1_sel = in_instr[19:15]; dec.rs2_sel = in_instr[24:20]; dec.imm = sext(imm_s);
        dec.alu_sel = 1'b1; dec.data_w = 1'b1; dec.data_size = f3[1:0];
      end
      7'b0010011: begin  // OP-IMM
        dec.rd_sel = in_instr[11:7]; dec.rs1_sel = in_instr[19:15];
        dec.alu_sel = 1'b1; dec.reg_w = 1'b1; dec.is_unsigned = (f3 == 3'b011);
        if (f3[1:0] == 2'b01) begin
          legal   = (f7_shift == 7'b0) || (f3[2] && f7_shift == 7'b0100000);
          dec.imm = XLEN'(shamt);
          f7_keep = f7_shift[5:0];
        end else begin
          legal   = 1'b1;
          dec.imm = sext(imm_i);
        end
      end
      7'b0110011: begin  // OP
        legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        dec.rd_sel = in_instr[11:7]; dec.rs1_sel = in_instr[19:15]; dec.rs2_sel = in_instr[24:20];
        dec.alu_sel = 1'b1; dec.reg_w = 1'b1; dec.is_unsigned = (f3 == 3'b011); f7_keep = f7[5:0];
      end
      7'b0001111: if (f3 == 3'b000) begin  // FENCE, PAUSE
        legal = 1'b1; dec.imm = sext(imm_i);
        dec.pause = PAUSE_EN && (in_instr == 32'h0100000F);
      end
      7'b1110011: if (in_instr == 32'h00000073 || in_instr == 32'h00100073) begin
        legal = 1'b1; dec.imm = sext(imm_i);
      end
      default: legal = 1'b0;
    endcase
    dec.op_code = {f7_keep, f3_keep, opc};
    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.op_code = {f7[5:0], f3, opc};
      dec.illegal = 1'b1;
    end
  end

  logic   out_valid_reg, skid_valid_reg, in_ready_reg, pause_busy_reg;
  logic   skid_valid_next, pause_busy_next;
  logic   accept, transfer, pause_start, pause_end;
  state_t state_reg;
  logic [7:0] cnt_reg;

  assign accept          = in_valid & in_ready_reg;
  assign transfer        = out_valid_reg & out_ready;
  assign pause_start     = accept & dec.pause & (PAUSE_CYCLES != 0);
  assign pause_end       = (state_reg == ST_PAUSE) && (cnt_reg == 8'd1);
  assign skid_valid_next = (!out_valid_reg || transfer) ? 1'b0 : (skid_valid_reg | accept);
  assign pause_busy_next = pause_start | (pause_busy_reg & ~pause_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
      in_ready_reg   <= 1'b1;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      if (!out_valid_reg || transfer) begin
        if (skid_valid_reg) begin
          out_reg       <= skid_reg;
          out_valid_reg <= 1'b1;
        end else if (accept) begin
          out_reg       <= dec;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_reg <= dec;
      end
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next & ~pause_busy_next;
    end
  end

  // Pause stall: counter is loaded on acceptance and the stall ends the cycle after it reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      cnt_reg        <= 8'd0;
      pause_busy_reg <= 1'b0;
    end else if (flush) begin
      state_reg      <= ST_RUN;
      cnt_reg        <= 8'd0;
      pause_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: if (pause_start) begin
          state_reg      <= ST_PAUSE;
          cnt_reg        <= PAUSE_LOAD;
          pause_busy_reg <= 1'b1;
        end
        ST_PAUSE: if (pause_end) begin
          state_reg      <= ST_RUN;
          cnt_reg        <= 8'd0;
          pause_busy_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg - 8'd1;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_reg;
  assign pause_busy      = pause_busy_reg;
  assign out_valid       = out_valid_reg;
  assign out_pc          = out_reg.pc;
  assign out_op_code     = out_reg.op_code;
  assign out_rs1_sel     = out_reg.rs1_sel;
  assign out_rs2_sel     = out_reg.rs2_sel;
  assign out_rd_sel      = out_reg.rd_sel;
  assign out_imm         = out_reg.imm;
  assign out_rd_data_sel = out_reg.rd_data_sel;
  assign out_alu_sel     = out_reg.alu_sel;
  assign out_reg_w       = out_reg.reg_w;
  assign out_data_r      = out_reg.data_r;
  assign out_data_w      = out_reg.data_w;
  assign out_data_size   = out_reg.data_size;
  assign out_unsigned    = out_reg.is_unsigned;
  assign out_branch      = out_reg.branch;
  assign out_jump        = out_reg.jump;
  assign out_illegal     = out_reg.illegal;
  assign out_pause       = out_reg.pause;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit instance with a 4-cycle pause
// stall and a 64-bit instance for wide-immediate and mid-stream reset checks.
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  int errors = 0, checks = 0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm;
  logic [15:0] out_op_code;
  logic [4:0]  out_rs1_sel, out_rs2_sel, out_rd_sel;
  logic [1:0]  out_rd_data_sel, out_data_size;
  logic        out_alu_sel, out_reg_w, out_data_r, out_data_w, out_unsigned;
  logic        out_branch, out_jump, out_illegal, out_pause, pause_busy;

  logic        x_in_valid = 1'b0, x_in_ready, x_out_valid, x_out_ready = 1'b0;
  logic [31:0] x_in_instr = '0;
  logic [63:0] x_in_pc = '0, x_out_pc, x_out_imm;
  logic [15:0] x_out_op_code;
  logic [4:0]  x_out_rs1_sel, x_out_rs2_sel, x_out_rd_sel;
  logic [1:0]  x_out_rd_data_sel, x_out_data_size;
  logic        x_out_alu_sel, x_out_reg_w, x_out_data_r, x_out_data_w, x_out_unsigned;
  logic        x_out_branch, x_out_jump, x_out_illegal, x_out_pause, x_pause_busy;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PAUSE_CYCLES(4), .PAUSE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op_code(out_op_code), .out_rs1_sel(out_rs1_sel),
    .out_rs2_sel(out_rs2_sel), .out_rd_sel(out_rd_sel), .out_imm(out_imm),
    .out_rd_data_sel(out_rd_data_sel), .out_alu_sel(out_alu_sel), .out_reg_w(out_reg_w),
    .out_data_r(out_data_r), .out_data_w(out_data_w), .out_data_size(out_data_size),
    .out_unsigned(out_unsigned), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal), .out_pause(out_pause), .pause_busy(pause_busy));

  decode_stage #(.XLEN(64), .PAUSE_CYCLES(16), .PAUSE_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .in_instr(x_in_instr), .in_pc(x_in_pc), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .out_pc(x_out_pc), .out_op_code(x_out_op_code), .out_rs1_sel(x_out_rs1_sel),
    .out_rs2_sel(x_out_rs2_sel), .out_rd_sel(x_out_rd_sel), .out_imm(x_out_imm),
    .out_rd_data_sel(x_out_rd_data_sel), .out_alu_sel(x_out_alu_sel), .out_reg_w(x_out_reg_w),
    .out_data_r(x_out_data_r), .out_data_w(x_out_data_w), .out_data_size(x_out_data_size),
    .out_unsigned(x_out_unsigned), .out_branch(x_out_branch), .out_jump(x_out_jump),
    .out_illegal(x_out_illegal), .out_pause(x_out_pause), .pause_busy(x_pause_busy));

  always @(posedge clk) begin
    if (out_valid && out_ready)
      $display("xfer32 pc=%h op=%h rd=%0d imm=%h ill=%b", out_pc, out_op_code, out_rd_sel, out_imm, out_illegal);
    if (x_out_valid && x_out_ready)
      $display("xfer64 pc=%h op=%h rd=%0d imm=%h ill=%b", x_out_pc, x_out_op_code, x_out_rd_sel, x_out_imm, x_out_illegal);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (pause_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", pause_busy); end
    checks++; if ({out_imm, out_pc, out_op_code, out_rd_sel, out_reg_w} !== '0) begin errors++;
      $display("FAIL reset_fields: got imm=%h pc=%h op=%h want 0", out_imm, out_pc, out_op_code); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    tick();
    in_instr = 32'h0040A103; in_pc = 32'h104;
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_rd_sel !== 5'd1) begin errors++;
      $display("FAIL addi_fields: got v=%b imm=%h rd=%0d want 1/5/1", out_valid, out_imm, out_rd_sel); end
    checks++; if (out_reg_w !== 1'b1 || out_alu_sel !== 1'b1 || out_op_code !== 16'h0013 || out_pc !== 32'h100) begin errors++;
      $display("FAIL addi_ctrl: got w=%b alu=%b op=%h pc=%h want 1/1/0013/100", out_reg_w, out_alu_sel, out_op_code, out_pc); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data_r !== 1'b1 || out_data_size !== 2'b10 || out_rd_data_sel !== 2'b01) begin errors++;
      $display("FAIL lw_ctrl: got v=%b r=%b sz=%b sel=%b want 1/1/10/01", out_valid, out_data_r, out_data_size, out_rd_data_sel); end
    checks++; if (out_imm !== 32'd4 || out_rd_sel !== 5'd2 || out_rs1_sel !== 5'd1 || out_op_code !== 16'h0103) begin errors++;
      $display("FAIL lw_fields: got imm=%h rd=%0d rs1=%0d op=%h want 4/2/1/0103", out_imm, out_rd_sel, out_rs1_sel, out_op_code); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h200;
    tick();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_rd_sel !== 5'd3) begin errors++;
      $display("FAIL bp_first: got v=%b rdy=%b rd=%0d want 1/1/3", out_valid, in_ready, out_rd_sel); end
    in_instr = 32'h00200213; in_pc = 32'h204;
    tick();
    checks++; if (in_ready !== 1'b0 || out_rd_sel !== 5'd3) begin errors++;
      $display("FAIL bp_skid_full: got rdy=%b rd=%0d want 0/3", in_ready, out_rd_sel); end
    in_instr = 32'h00300293; in_pc = 32'h208;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'd1) begin errors++;
      $display("FAIL bp_hold: got rdy=%b v=%b pc=%h imm=%h want 0/1/200/1", in_ready, out_valid, out_pc, out_imm); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd_sel !== 5'd4 || out_pc !== 32'h204 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_second: got v=%b rd=%0d pc=%h rdy=%b want 1/4/204/1", out_valid, out_rd_sel, out_pc, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd_sel !== 5'd5 || out_imm !== 32'd3 || out_pc !== 32'h208) begin errors++;
      $display("FAIL bp_third: got v=%b rd=%0d imm=%h pc=%h want 1/5/3/208", out_valid, out_rd_sel, out_imm, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_pause();
    int busy_cycles = 0, seen_at = -1;
    logic ready_in_stall = 1'b0, drained = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0100000F; in_pc = 32'h300;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pause !== 1'b1 || out_reg_w !== 1'b0 || out_alu_sel !== 1'b0 || out_illegal !== 1'b0) begin errors++;
      $display("FAIL pause_decode: got v=%b p=%b w=%b alu=%b ill=%b want 1/1/0/0/0", out_valid, out_pause, out_reg_w, out_alu_sel, out_illegal); end
    in_instr = 32'h00600313; in_pc = 32'h304;
    for (int i = 0; i < 12; i++) begin
      if (pause_busy) busy_cycles++;
      if (pause_busy && in_ready) ready_in_stall = 1'b1;
      if (i == 1) drained = ~out_valid;
      if (out_valid && out_rd_sel == 5'd6) begin seen_at = i; break; end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL pause_busy_len: got %0d want 4", busy_cycles); end
    checks++; if (seen_at != 5) begin errors++; $display("FAIL pause_next_accept: got cycle %0d want 5", seen_at); end
    checks++; if (ready_in_stall !== 1'b0 || drained !== 1'b1) begin errors++;
      $display("FAIL pause_ready_drain: got ready_in_stall=%b drained=%b want 0/1", ready_in_stall, drained); end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] vec [4] = '{32'hFFFFFFFF, 32'h40002033, 32'h00500092, 32'h4210D093};
    out_ready = 1'b1; in_valid = 1'b1;
    foreach (vec[i]) begin
      in_instr = vec[i]; in_pc = 32'h400 + 32'(i) * 4;
      tick();
      checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_w !== 1'b0 || out_data_w !== 1'b0 ||
                     out_branch !== 1'b0 || out_jump !== 1'b0 || out_rd_sel !== 5'd0) begin errors++;
        $display("FAIL illegal_%h: got v=%b ill=%b w=%b dw=%b br=%b j=%b rd=%0d want 1/1/0/0/0/0/0",
                 vec[i], out_valid, out_illegal, out_reg_w, out_data_w, out_branch, out_jump, out_rd_sel); end
    end
    in_instr = 32'h403100B3; in_pc = 32'h410;
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b0 || out_op_code !== 16'h8033 || out_rs2_sel !== 5'd3 || out_rs1_sel !== 5'd2 || out_imm !== 32'd0) begin errors++;
      $display("FAIL sub_legal: got ill=%b op=%h rs2=%0d rs1=%0d imm=%h want 0/8033/3/2/0", out_illegal, out_op_code, out_rs2_sel, out_rs1_sel, out_imm); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h500;
    tick();
    in_instr = 32'h00200213; in_pc = 32'h504;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: got rdy=%b want 0", in_ready); end
    flush = 1'b1; in_instr = 32'h00300293; in_pc = 32'h508;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pause_busy !== 1'b0) begin errors++;
      $display("FAIL flush_skid: got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, pause_busy); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got v=%b want 0", out_valid); end
    in_valid = 1'b1; in_instr = 32'h0100000F; in_pc = 32'h50C;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    checks++; if (pause_busy !== 1'b1) begin errors++; $display("FAIL flush_pause_setup: got busy=%b want 1", pause_busy); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pause_busy !== 1'b0) begin errors++;
      $display("FAIL flush_pause: got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, pause_busy); end
    in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h510;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd_sel !== 5'd7 || out_imm !== 32'd7 || out_illegal !== 1'b0 || out_pc !== 32'h510) begin errors++;
      $display("FAIL flush_resume: got v=%b rd=%0d imm=%h ill=%b pc=%h want 1/7/7/0/510", out_valid, out_rd_sel, out_imm, out_illegal, out_pc); end
    tick();
  endtask

  task automatic test_xlen64();
    x_out_ready = 1'b1; x_in_valid = 1'b1; x_in_instr = 32'hFE000EE3; x_in_pc = 64'h1_0000_0000;
    tick();
    x_in_instr = 32'h4210D093; x_in_pc = 64'h1_0000_0004;
    checks++; if (x_out_valid !== 1'b1 || x_out_imm !== 64'hFFFFFFFFFFFFFFFC || x_out_branch !== 1'b1) begin errors++;
      $display("FAIL beq64: got v=%b imm=%h br=%b want 1/fffffffffffffffc/1", x_out_valid, x_out_imm, x_out_branch); end
    checks++; if (x_out_rs1_sel !== 5'd0 || x_out_rs2_sel !== 5'd0 || x_out_rd_sel !== 5'd0 || x_out_op_code !== 16'h0063 || x_out_pc !== 64'h1_0000_0000) begin errors++;
      $display("FAIL beq64_fields: got rs1=%0d rs2=%0d rd=%0d op=%h pc=%h want 0/0/0/0063/100000000", x_out_rs1_sel, x_out_rs2_sel, x_out_rd_sel, x_out_op_code, x_out_pc); end
    tick();
    x_out_ready = 1'b0; x_in_instr = 32'h00500093; x_in_pc = 64'h1_0000_0008;
    checks++; if (x_out_illegal !== 1'b0 || x_out_imm !== 64'd33 || x_out_op_code !== 16'h8293) begin errors++;
      $display("FAIL srai64: got ill=%b imm=%h op=%h want 0/21/8293", x_out_illegal, x_out_imm, x_out_op_code); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x_out_valid !== 1'b0 || x_out_imm !== 64'd0 || x_in_ready !== 1'b1 || x_out_pc !== 64'd0 || x_out_branch !== 1'b0) begin errors++;
      $display("FAIL async_reset: got v=%b imm=%h rdy=%b pc=%h want 0/0/1/0", x_out_valid, x_out_imm, x_in_ready, x_out_pc); end
    x_in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (x_out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_bundle: got v=%b want 0", x_out_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_pause();
    test_illegal();
    test_flush();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
